dmem_pipelined: RTL and testbench
=================================

# dmem_pipelined

Parametrised, pipelined byte-addressable data memory for the core's MEM stage, successor to the single-cycle combinational-read data memory. It accepts one load or store per cycle over a valid/ready request port and returns a response exactly `READ_LATENCY` cycles later. It adds signed/unsigned loads, fault reporting for misaligned, reserved-size and out-of-range accesses, and a hardware zero-initialisation sweep after reset instead of a single-edge array clear.

## Interface

Parameters:

- `XLEN`, 32: data and address width; only 32 is supported.
- `DEPTH_BYTES`, 4096: memory size in bytes; power of two, ≥16; word count `DEPTH_WORDS = DEPTH_BYTES/4`.
- `READ_LATENCY`, 1: cycles from request acceptance to response; legal range 1..4.

Ports (clock and reset first):

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: reset, asynchronous assert, active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block can accept a request.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, XLEN: byte address.
- `req_wdata`, in, XLEN: store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_size`, in, 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`, in, 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_rdata`, out, XLEN: load result; 0 for stores and faults.
- `rsp_fault`, out, 1: request faulted; qualified by `rsp_valid`.
- `init_done`, out, 1: zero sweep complete.

## Operation

Storage and acceptance:

- Storage is `DEPTH_WORDS` × 32-bit words with four byte lanes. Word index = `req_addr[log2(DEPTH_BYTES)-1:2]`; lane = `req_addr[1:0]`.
- Accept = `req_valid && req_ready`. `req_ready = init_done`. There is no response backpressure; the consumer always takes `rsp_*`.

Fault conditions. A request faults if any of these hold:

- `req_size` = 11;
- half with `req_addr[0]` = 1;
- word with `req_addr[1:0]` ≠ 00;
- `req_addr` ≥ `DEPTH_BYTES`.

A faulting request writes nothing and returns `rsp_fault` = 1, `rsp_rdata` = 0.

Store behaviour:

- Byte store writes `wdata[7:0]` into lane `addr[1:0]`.
- Half store writes `wdata[15:0]` into lanes {`addr[1]`·2 + 1, `addr[1]`·2}.
- Word store writes all four lanes.
- Other lanes are unchanged.
- A store response carries `rsp_rdata` = 0, `rsp_fault` = 0.

Load behaviour:

- The selected byte or half is extended to 32 bits per `req_unsigned`.
- Word loads ignore `req_unsigned`.

Init FSM states:

- INIT:
  - Entered on reset.
  - Sweep counter starts at 0 and writes word[counter] = 0 each cycle.
  - When the counter reaches `DEPTH_WORDS-1`, the write is done and the FSM moves to READY, so the sweep takes exactly `DEPTH_WORDS` cycles.
  - `init_done` = 0, `req_ready` = 0 throughout.
- READY: `init_done` = 1. The FSM stays in READY until reset.

Reset:

- Asserting `reset_n` low at any time clears all pipeline valid bits, drops in-flight responses, forces INIT and resets the sweep counter to 0.
- Array contents are not otherwise reset; the sweep provides the clear.

## Timing

Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_fault` = 0, `init_done` = 0.

- The sweep begins on the first rising edge after `reset_n` goes high. `init_done` rises after `DEPTH_WORDS` edges.
- Throughput is one request per cycle, fully pipelined.
- A request accepted at edge E produces `rsp_valid` = 1 for exactly the one cycle following edge E+`READ_LATENCY`−1. With `READ_LATENCY` = 1, the response is registered and visible in the cycle right after acceptance.
- Responses return in request order. Back-to-back requests give back-to-back `rsp_valid` pulses.
- The store write commits at the accepting edge.
- The load reads the array at its accepting edge. A load accepted the cycle after a store to the same word therefore sees the stored data, for any `READ_LATENCY`.
- `rsp_rdata` and `rsp_fault` are 0 whenever `rsp_valid` = 0.

## Test plan

- **Init sweep.** `DEPTH_BYTES`=64. Release reset, hold `req_valid`=1.
  - Expect `req_ready`=0 for 16 cycles, then `init_done`=`req_ready`=1.
  - A word load of 0x3C then returns 0x00000000.
- **Byte and half lanes, sign handling.**
  - Word store 0x0: 0x80FF7F01.
  - Byte loads: 0x1 signed → 0x0000007F; 0x2 signed → 0xFFFFFFFF; 0x3 unsigned → 0x00000080.
  - Half loads: 0x2 signed → 0xFFFF80FF; 0x0 unsigned → 0x00007F01.
- **Partial store.** Word store 0x8: 0x11223344, then half store 0xA with wdata 0x0000BEEF.
  - Word load 0x8 → 0xBEEF3344.
- **Faults.** Each case gives `rsp_fault`=1, `rsp_rdata`=0:
  - half load at 0x5;
  - word store at 0x6 (a later word load of 0x4 shows the old data);
  - `req_size`=11;
  - address = `DEPTH_BYTES`.
- **Latency and back-to-back.** `READ_LATENCY`=3: store then load to the same address on consecutive cycles.
  - Pulses appear 3 cycles after each accept, in order.
  - The load returns the stored value.
- **Reset mid-operation.** Assert `reset_n` with 2 responses in flight.
  - `rsp_valid` drops immediately and no stale response appears.
  - INIT restarts.
  - A load of a previously written address after `init_done` returns 0.

Source files
------------

// File: rtl/dmem_pipelined.sv
// dmem_pipelined: pipelined byte-addressable data memory for the MEM stage.
// One load/store accepted per cycle; each response (data or fault) comes back
// exactly READ_LATENCY cycles after acceptance, in request order. After reset
// a sweep FSM writes zero to every word before requests are accepted.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// are both high. req_ready depends only on internal state (never on req_valid).
// The response side has no backpressure: rsp_valid is a one-cycle pulse that
// the consumer must take; rsp_rdata/rsp_fault are zero whenever rsp_valid is 0.
//
// Supported configuration: XLEN = 32, DEPTH_BYTES a power of two >= 16,
// READ_LATENCY in 1..4.
module dmem_pipelined #(
    parameter int XLEN         = 32,
    parameter int DEPTH_BYTES  = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault,
    output logic            init_done
);

    localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
    localparam int ABITS       = $clog2(DEPTH_BYTES);
    localparam int IBITS       = ABITS - 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Init FSM encoding
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // One pipeline slot: the raw word is captured at the accepting edge and
    // the lane extraction / extension is done on the way out.
    typedef struct packed {
        logic            valid;
        logic            load;
        logic            fault;
        logic [1:0]      size;
        logic            uns;
        logic [1:0]      lane;
        logic [XLEN-1:0] word;
    } stage_t;

    logic [0:0]       state_q, state_d;
    logic [IBITS-1:0] sweep_q, sweep_d;
    logic             sweep_we;

    logic             accept;
    logic             req_fault;
    logic             out_of_range;
    logic             misaligned;
    logic [IBITS-1:0] req_idx;
    logic [1:0]       req_lane;
    logic             wr_en;
    logic [3:0]       wr_be;
    logic [XLEN-1:0]  wr_data;
    logic [XLEN-1:0]  rd_word;

    logic [XLEN-1:0]  mem_q [DEPTH_WORDS];

    stage_t           pipe_q [READ_LATENCY];
    stage_t           pipe_d [READ_LATENCY];

    stage_t           last;
    logic [XLEN-1:0]  last_shifted;
    logic [7:0]       last_byte;
    logic [15:0]      last_half;
    logic [XLEN-1:0]  last_fmt;

    // Init FSM next state: sweep one word per cycle, then hold READY forever.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        sweep_we = 1'b0;
        if (state_q == ST_INIT) begin
            sweep_we = 1'b1;
            if (sweep_q == IBITS'(DEPTH_WORDS - 1)) begin
                state_d = ST_READY;
            end else begin
                sweep_d = sweep_q + 1'b1;
            end
        end
    end

    // Init FSM state and sweep counter; reset restarts the sweep from word 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    assign init_done = (state_q == ST_READY);
    assign req_ready = init_done;
    assign accept    = req_valid && req_ready;

    // Request decode: fault classification, word index and store lane mask.
    always_comb begin
        req_idx      = req_addr[ABITS-1:2];
        req_lane     = req_addr[1:0];
        out_of_range = (req_addr[XLEN-1:ABITS] != '0);
        misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        req_fault    = (req_size == 2'b11) || misaligned || out_of_range;
        wr_en        = accept && req_we && !req_fault;

        wr_be   = 4'b0000;
        wr_data = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                wr_data = {4{req_wdata[7:0]}};
                wr_be   = 4'b0001 << req_lane;
            end
            SZ_HALF: begin
                wr_data = {2{req_wdata[15:0]}};
                wr_be   = req_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = req_wdata;
                wr_be   = 4'b1111;
            end
        endcase

        rd_word = mem_q[req_idx];
    end

    // Storage array: the init sweep and accepted stores are mutually exclusive
    // because requests are only accepted once the sweep has finished. The
    // sweep also rewrites word 0 with zero while reset is held, which is benign.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[sweep_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Pipeline next state: slot 0 captures the accepted request, the rest shift.
    always_comb begin
        pipe_d[0]       = '0;
        pipe_d[0].valid = accept;
        pipe_d[0].load  = accept && !req_we && !req_fault;
        pipe_d[0].fault = accept && req_fault;
        pipe_d[0].size  = req_size;
        pipe_d[0].uns   = req_unsigned;
        pipe_d[0].lane  = req_lane;
        pipe_d[0].word  = (accept && !req_we && !req_fault) ? rd_word : '0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline registers; reset discards every in-flight response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Response formatting: pick byte/half from the captured word and extend.
    always_comb begin
        last         = pipe_q[READ_LATENCY-1];
        last_shifted = last.word >> {last.lane, 3'b000};
        last_byte    = last_shifted[7:0];
        last_half    = last.lane[1] ? last.word[31:16] : last.word[15:0];
        case (last.size)
            SZ_BYTE: last_fmt = {{24{!last.uns && last_byte[7]}}, last_byte};
            SZ_HALF: last_fmt = {{16{!last.uns && last_half[15]}}, last_half};
            default: last_fmt = last.word;
        endcase

        rsp_valid = last.valid;
        rsp_fault = last.valid && last.fault;
        rsp_rdata = (last.valid && last.load) ? last_fmt : '0;
    end

endmodule

// File: tb/tb_dmem_pipelined.sv
// tb_dmem_pipelined: directed and random checks of dmem_pipelined against a
// byte-array reference model. Requests are driven on the falling edge; the
// expected response and its due cycle are queued at drive time and checked
// 1 time unit after each rising edge.
module tb_dmem_pipelined;

  localparam int XLEN         = 32;
  localparam int DEPTH_BYTES  = 64;
  localparam int DEPTH_WORDS  = DEPTH_BYTES / 4;
  localparam int READ_LATENCY = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic [1:0]      req_size = 2'b00;
  logic            req_unsigned = 1'b0;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;
  logic            init_done;

  dmem_pipelined #(
    .XLEN(XLEN),
    .DEPTH_BYTES(DEPTH_BYTES),
    .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault),
    .init_done(init_done)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mem_m [DEPTH_BYTES];
  logic       exp_ready = 1'b0;
  // entry = {due_cycle[31:0], fault, rdata[31:0]}
  logic [64:0] exp_q[$];

  task automatic model_clear();
    for (int i = 0; i < DEPTH_BYTES; i++) mem_m[i] = 8'h00;
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns,
                              output logic [31:0] rdata, output logic fault);
    int nb;
    logic [31:0] v;
    logic [31:0] mask;
    nb    = 1 << size;
    fault = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'(DEPTH_BYTES));
    rdata = 32'h0;
    if (!fault) begin
      if (we) begin
        for (int b = 0; b < nb; b++) mem_m[int'(addr) + b] = wdata[8*b +: 8];
      end else begin
        v = 32'h0;
        for (int b = 0; b < nb; b++) v[8*b +: 8] = mem_m[int'(addr) + b];
        if (!uns && nb < 4 && v[8*nb-1]) begin
          mask = (32'h1 << (8*nb)) - 32'h1;
          v = v | ~mask;
        end
        rdata = v;
      end
    end
  endtask

  // Response checker: a response is due exactly on the cycle recorded at drive time.
  always @(posedge clk) begin
    logic [64:0] head;
    #1;
    if (exp_q.size() != 0 && exp_q[0][64:33] == 32'(cyc)) begin
      head = exp_q.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'h1);
      check("rsp_fault", 32'(rsp_fault), 32'(head[32]));
      check("rsp_rdata", rsp_rdata, head[31:0]);
    end else begin
      check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
      check("idle_rsp_rdata", rsp_rdata, 32'h0);
      check("idle_rsp_fault", 32'(rsp_fault), 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; presents one request for the next rising edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    logic [31:0] rd;
    logic        flt;
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    if (exp_ready) begin
      model_access(we, addr, wdata, size, uns, rd, flt);
      exp_q.push_back({32'(cyc + READ_LATENCY), flt, rd});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Releases reset at a falling edge and checks the sweep length exactly.
  task automatic init_sequence();
    reset_n = 1'b1;
    check("init_ready_c0", 32'(req_ready), 32'h0);
    check("init_done_c0", 32'(init_done), 32'h0);
    for (int i = 1; i < DEPTH_WORDS; i++) begin
      @(negedge clk);
      check("init_ready_low", 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    check("init_ready_high", 32'(req_ready), 32'h1);
    check("init_done_high", 32'(init_done), 32'h1);
    exp_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_fault", 32'(rsp_fault), 32'h0);
    check("reset_init_done", 32'(init_done), 32'h0);

    // Init sweep with req_valid held high: nothing may be accepted early.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h3C;
    req_size  = 2'b10;
    init_sequence();
    issue(1'b0, 32'h3C, 32'h0, 2'b10, 1'b0);

    // Byte/half lanes and sign handling.
    issue(1'b1, 32'h0, 32'h80FF7F01, 2'b10, 1'b0);
    issue(1'b0, 32'h1, 32'h0, 2'b00, 1'b0);
    issue(1'b0, 32'h2, 32'h0, 2'b00, 1'b0);
    issue(1'b0, 32'h3, 32'h0, 2'b00, 1'b1);
    issue(1'b0, 32'h2, 32'h0, 2'b01, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 2'b01, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 2'b10, 1'b1);
    idle(2);

    // Partial store.
    issue(1'b1, 32'h8, 32'h11223344, 2'b10, 1'b0);
    issue(1'b1, 32'hA, 32'h0000BEEF, 2'b01, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 2'b10, 1'b0);
    idle(1);

    // Faults.
    issue(1'b1, 32'h4, 32'hA5A5A5A5, 2'b10, 1'b0);
    issue(1'b0, 32'h5, 32'h0, 2'b01, 1'b0);
    issue(1'b1, 32'h6, 32'hDEADBEEF, 2'b10, 1'b0);
    issue(1'b0, 32'h4, 32'h0, 2'b10, 1'b0);
    issue(1'b0, 32'h4, 32'h0, 2'b11, 1'b0);
    issue(1'b1, 32'h4, 32'h12345678, 2'b11, 1'b0);
    issue(1'b0, 32'(DEPTH_BYTES), 32'h0, 2'b00, 1'b0);
    issue(1'b1, 32'(DEPTH_BYTES), 32'hFFFFFFFF, 2'b10, 1'b0);
    issue(1'b0, 32'h4, 32'h0, 2'b10, 1'b0);
    idle(2);

    // Latency / back-to-back store then load of the same word.
    issue(1'b1, 32'h20, 32'h5A5AC3C3, 2'b10, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    issue(1'b1, 32'h21, 32'h00000077, 2'b00, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    idle(READ_LATENCY + 1);

    // Random traffic, occasionally out of range or misaligned.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 4) == 0) begin
        idle($urandom_range(1, 3));
      end else begin
        case ($urandom_range(0, 9))
          0:       a = 32'(DEPTH_BYTES) + 32'($urandom_range(0, 63));
          1:       a = $urandom();
          default: a = 32'($urandom_range(0, DEPTH_BYTES - 1));
        endcase
        issue(1'($urandom_range(0, 1)), a, $urandom(),
              ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)));
      end
    end
    idle(READ_LATENCY + 2);
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    // Reset with one response visible and two in flight.
    issue(1'b1, 32'h10, 32'hCAFEF00D, 2'b10, 1'b0);
    idle(1);
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 2'b00, 1'b0);
    issue(1'b0, 32'h12, 32'h0, 2'b01, 1'b0);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("reset_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_mid_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_mid_ready", 32'(req_ready), 32'h0);
    exp_q.delete();
    exp_ready = 1'b0;
    model_clear();
    @(negedge clk);
    idle(2);
    init_sequence();
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 2'b10, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    idle(READ_LATENCY + 2);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
